// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, the imem request/ready handshake, redirect handling
// and a one-entry skid buffer. Optional perf counters are enabled by defining IF_PERF_CNT_EN.
module if_stage #(
  parameter int unsigned              PC_WIDTH    = 32,
  parameter int unsigned              INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]      RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0]   NOP_INSTR   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_pipeline,
  input  logic                   is_jump,
  input  logic [PC_WIDTH-1:0]    jump_addr,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_addr,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ready,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]            perf_fetch_cnt,
  output logic [31:0]            perf_bubble_cnt,
`endif
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]    pc
);

  typedef enum logic [1:0] {
    ST_RST_WAIT = 2'd0,
    ST_FETCH    = 2'd1,
    ST_HOLD     = 2'd2,
    ST_DROP     = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0]    imem_addr_q, imem_addr_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic [PC_WIDTH-1:0]    skid_pc_q, skid_pc_d;

  logic                   redirect;
  logic [PC_WIDTH-1:0]    target;
  logic                   load_fetch;
  logic                   load_nop;

  // A branch in MEM is older than a jump in ID, so it wins.
  assign redirect = branch_taken | is_jump;
  assign target   = branch_taken ? branch_addr : jump_addr;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    load_fetch   = 1'b0;
    load_nop     = 1'b0;

    if (redirect) begin
      fetch_pc_d   = target;
      instr_d      = NOP_INSTR;
      load_nop     = 1'b1;
      skid_instr_d = NOP_INSTR;
      skid_pc_d    = RESET_PC;
      // A request still in flight must complete before the new address may be issued.
      if ((state_q == ST_FETCH || state_q == ST_DROP) && !imem_ready) begin
        state_d = ST_DROP;
      end else begin
        state_d = ST_FETCH;
      end
    end else begin
      unique case (state_q)
        ST_RST_WAIT: begin
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_ready) begin
            fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
            if (!stall_pipeline) begin
              instr_d    = imem_rdata;
              pc_d       = fetch_pc_q;
              load_fetch = 1'b1;
            end else begin
              skid_instr_d = imem_rdata;
              skid_pc_d    = fetch_pc_q;
              state_d      = ST_HOLD;
            end
          end else if (!stall_pipeline) begin
            instr_d  = NOP_INSTR;
            load_nop = 1'b1;
          end
        end
        ST_HOLD: begin
          // Being in HOLD is itself the skid-full indication.
          if (!stall_pipeline) begin
            instr_d    = skid_instr_q;
            pc_d       = skid_pc_q;
            load_fetch = 1'b1;
            state_d    = ST_FETCH;
          end
        end
        ST_DROP: begin
          if (!stall_pipeline) begin
            instr_d  = NOP_INSTR;
            load_nop = 1'b1;
          end
          if (imem_ready) begin
            state_d = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_RST_WAIT;
        end
      endcase
    end

    // The stale address stays on the bus until its transfer completes.
    imem_addr_d = (state_d == ST_DROP) ? imem_addr_q : fetch_pc_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RST_WAIT;
      fetch_pc_q   <= RESET_PC;
      imem_addr_q  <= RESET_PC;
      instr_q      <= NOP_INSTR;
      pc_q         <= RESET_PC;
      // NOTE: the skid entry is reset too; it is a single register, not a memory array.
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      imem_addr_q  <= imem_addr_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign imem_req    = (state_q == ST_FETCH) || (state_q == ST_DROP);
  assign imem_addr   = imem_addr_q;
  assign instruction = instr_q;
  assign pc          = pc_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + {31'b0, load_fetch};
    bubble_cnt_d = bubble_cnt_q + {31'b0, load_nop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule
